// File: rtl/alu_control_mdu.sv
// ALU control decode with JR flag, plus an iterative multiply/divide unit
// (HI/LO registers, MFHI/MFLO readback) that stalls the pipeline while busy.
module alu_control_mdu #(
    parameter  int DATA_W  = 32,
    parameter  int ALUOP_W = 4,
    localparam int CNT_W   = $clog2(DATA_W) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [5:0]         ALUFunction,
    input  logic               instr_valid,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    output logic [3:0]         ALUOperation,
    output logic               JR,
    output logic               mdu_stall,
    output logic [DATA_W-1:0]  mdu_result,
    output logic               mdu_sel
);

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_JR   = 6'b001000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   work;
    logic [2*DATA_W-1:0]   work_nxt;
    logic [DATA_W-1:0]     opnd;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic [DATA_W-1:0]     hi_fin;
    logic [DATA_W-1:0]     lo_fin;
    logic                  op_div;
    logic                  neg_res;
    logic                  neg_rem;
    logic                  div0;

    logic                  is_rtype;
    logic                  is_mdu;
    logic                  in_signed;
    logic                  in_div;
    logic                  start;
    logic                  last;
    logic                  rs_neg;
    logic                  rt_neg;
    logic [DATA_W-1:0]     rs_mag;
    logic [DATA_W-1:0]     rt_mag;

    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_shift;
    logic [DATA_W:0]       div_diff;
    logic [2*DATA_W-1:0]   prod;
    logic [DATA_W-1:0]     quo;
    logic [DATA_W-1:0]     rem;

    assign is_rtype  = (ALUOp == '0);
    assign is_mdu    = is_rtype && (ALUFunction[5:2] == 4'b0110);
    assign in_signed = ~ALUFunction[0];
    assign in_div    = ALUFunction[1];
    assign start     = instr_valid && is_mdu && (state == IDLE);
    assign last      = (state == BUSY) && (cnt == CNT_W'(DATA_W - 1));

    // Operation decode; funct only matters for R-type
    always_comb begin
        ALUOperation = 4'b1001;
        JR           = 1'b0;
        if (is_rtype) begin
            case (ALUFunction)
                F_AND:  ALUOperation = 4'b0000;
                F_OR:   ALUOperation = 4'b0001;
                F_NOR:  ALUOperation = 4'b0010;
                F_ADD:  ALUOperation = 4'b0011;
                F_SUB:  ALUOperation = 4'b0100;
                F_SLL:  ALUOperation = 4'b0110;
                F_SRL:  ALUOperation = 4'b0111;
                F_SLT:  ALUOperation = 4'b1000;
                F_MFHI, F_MFLO,
                6'b011000, 6'b011001,
                6'b011010, 6'b011011: ALUOperation = 4'b1010;
                F_JR:   JR = 1'b1;
                default: ALUOperation = 4'b1001;
            endcase
        end else begin
            case (ALUOp)
                ALUOP_W'(1): ALUOperation = 4'b0011;
                ALUOP_W'(2): ALUOperation = 4'b0001;
                ALUOP_W'(3): ALUOperation = 4'b0101;
                ALUOP_W'(4): ALUOperation = 4'b0000;
                ALUOP_W'(5): ALUOperation = 4'b0100;
                ALUOP_W'(6): ALUOperation = 4'b0100;
                ALUOP_W'(7): ALUOperation = 4'b0011;
                ALUOP_W'(8): ALUOperation = 4'b0011;
                default:     ALUOperation = 4'b1001;
            endcase
        end
    end

    assign rs_neg = in_signed && rs_data[DATA_W-1];
    assign rt_neg = in_signed && rt_data[DATA_W-1];
    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    // Both share work = {HI-side, LO-side}; opnd is multiplicand or divisor.
    always_comb begin
        mul_sum   = {1'b0, work[2*DATA_W-1:DATA_W]} + (work[0] ? {1'b0, opnd} : '0);
        div_shift = work[2*DATA_W-1:DATA_W-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (!op_div)
            work_nxt = {mul_sum, work[DATA_W-1:1]};
        else if (div_diff[DATA_W])
            work_nxt = {div_shift[DATA_W-1:0], work[DATA_W-2:0], 1'b0};
        else
            work_nxt = {div_diff[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
    end

    // Sign correction on the final step; a zero divisor forces an all-ones quotient
    always_comb begin
        prod = neg_res ? -work_nxt : work_nxt;
        quo  = work_nxt[DATA_W-1:0];
        rem  = work_nxt[2*DATA_W-1:DATA_W];
        if (op_div) begin
            lo_fin = div0 ? '1 : (neg_res ? -quo : quo);
            hi_fin = neg_rem ? -rem : rem;
        end else begin
            lo_fin = prod[DATA_W-1:0];
            hi_fin = prod[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: latch magnitudes on start, iterate in BUSY, commit HI/LO on the last step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            work    <= '0;
            opnd    <= '0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (start) begin
                cnt     <= '0;
                work    <= {{DATA_W{1'b0}}, (in_div ? rs_mag : rt_mag)};
                opnd    <= in_div ? rt_mag : rs_mag;
                op_div  <= in_div;
                neg_res <= rs_neg ^ rt_neg;
                neg_rem <= in_div && rs_neg;
                div0    <= (rt_data == '0);
            end else if (state == BUSY) begin
                cnt  <= cnt + CNT_W'(1);
                work <= work_nxt;
                if (last) begin
                    hi <= hi_fin;
                    lo <= lo_fin;
                end
            end
        end
    end

    // Stall is forced low while reset is asserted even if an MDU op is presented
    assign mdu_stall  = reset && (start || (state == BUSY));
    assign mdu_result = (is_rtype && (ALUFunction == F_MFHI)) ? hi : lo;
    assign mdu_sel    = is_rtype && ((ALUFunction == F_MFHI) || (ALUFunction == F_MFLO));

endmodule
